sliding_window_gen: RTL and testbench
=====================================

// Module: sliding_window_gen
// PURPOSE
//  Turns a raster-order pixel stream into KERNEL_SIZE x KERNEL_SIZE windows for the convolution blocks
//  (Gaussian, Sobel) that consume i_data/i_data_valid. Holds KERNEL_SIZE-1 line buffers plus a column
//  shift register. Emits one window per input pixel once the window lies fully inside the frame (no padding).
// PARAMETERS
//  NBIT         8    pixel bit-width
//  KERNEL_SIZE  3    window side (odd, >=3)
//  IMG_WIDTH    640  pixels per line (>= KERNEL_SIZE)
//  IMG_HEIGHT   480  lines per frame (>= KERNEL_SIZE)
// PORTS
//  i_clk          in   1                 clock, all logic rising-edge
//  i_rst_n        in   1                 reset, asynchronous, active-low
//  i_pixel        in   NBIT              input pixel, raster order
//  i_pixel_valid  in   1                 pixel accepted this cycle (no backpressure)
//  i_sof          in   1                 start of frame, qualified by i_pixel_valid; marks pixel (0,0)
//  o_window       out  NBIT x [K][K]     window; [0][0] = oldest row/col, [K-1][K-1] = newest pixel
//  o_window_valid out  1                 o_window holds a new complete window (one-cycle pulse)
//  o_frame_done   out  1                 one-cycle pulse after the last pixel of a frame
// BEHAVIOUR
//  Reset: FSM=S_IDLE, row/col counters=0, column shift register=0, o_window all 0, o_window_valid=0,
//   o_frame_done=0. Line buffer contents are don't-care (never exposed before being rewritten).
//  FSM: S_IDLE -> S_ACTIVE on i_pixel_valid & i_sof (that pixel is (0,0) and is processed).
//   S_ACTIVE -> S_IDLE on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
//   In S_IDLE, pixels without i_sof are dropped: no state change.
//   i_sof in S_ACTIVE: frame aborted, counters restart, the pixel becomes (0,0); no o_frame_done for the aborted frame.
//  Per accepted pixel at (row,col): read column col of all line buffers; form new column
//   {lb[K-2]..lb[0], i_pixel} (oldest row first); shift into the column register; write the pixel into
//   lb[0] and lb[k] <- lb[k-1] at address col. col wraps to 0 at IMG_WIDTH-1 and row increments.
//  Cycles with i_pixel_valid=0: nothing shifts or writes; o_window holds; o_window_valid=0.
//  Validity: o_window_valid=1 exactly one cycle after accepting a pixel with row>=K-1 and col>=K-1.
//   Columns col<K-1 never yield valid windows (this prevents wrap across lines).
//   Windows per frame = (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1).
//  Latency: 1 cycle (registered outputs). The window centre is (row-(K-1)/2, col-(K-1)/2).
//  o_frame_done is asserted in the same cycle as o_window_valid for the final window.
//  Reset asserted mid-frame: returns to S_IDLE at once, all outputs 0, and the partial frame is discarded.
//  The line buffers use one read and one write per cycle at the same address, with read-before-write semantics.
//   Either inferred RAM or registers is acceptable.
// CONFIGURATION
//  SLIDING_WINDOW_COORD_EN defined: adds outputs o_center_row [$clog2(IMG_HEIGHT)-1:0] and
//   o_center_col [$clog2(IMG_WIDTH)-1:0], the window centre coordinates, registered alongside o_window.
//   Reset value 0; they hold when o_window_valid=0.
//  Not defined: these ports and their logic are absent. All other behaviour is identical.
// TESTING  (IMG_WIDTH=5, IMG_HEIGHT=5, KERNEL_SIZE=3, NBIT=8, pixel = row*16+col)
//  1 Continuous frame, sof on (0,0) -> first o_window_valid the cycle after (2,2)
//    o_window = {{0,1,2},{16,17,18},{32,33,34}}; 9 valid windows total;
//    last window {{34,35,36},{50,51,52},{66,67,68}} arrives together with o_frame_done.
//  2 Same frame with random i_pixel_valid gaps (0-3 cycles) -> identical window sequence, no extra or missing valids.
//  3 Pixels sent while IDLE without i_sof, then a normal frame -> the leading pixels are ignored and the output matches test 1.
//  4 i_sof reasserted at (3,1) of frame A, then a full frame B
//    -> no o_frame_done for frame A; frame B produces exactly 9 correct windows.
//  5 i_rst_n pulled low mid-frame (asynchronously, between edges) -> outputs 0 immediately;
//    after release, a new frame is correct.
//  6 With SLIDING_WINDOW_COORD_EN -> first window centre (1,1), last window centre (3,3).
//    Without the macro, the build has no coordinate ports.

Source files
------------

// File: rtl/sliding_window_gen.sv
// Raster pixel stream to KERNEL_SIZE x KERNEL_SIZE window generator (line buffers + column shift register).
// Optional centre-coordinate outputs are enabled by defining SLIDING_WINDOW_COORD_EN.
module sliding_window_gen #(
   parameter int NBIT        = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst_n,
   input  logic [NBIT-1:0]                               i_pixel,
   input  logic                                          i_pixel_valid,
   input  logic                                          i_sof,
   output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] o_window,
   output logic                                          o_window_valid,
   output logic                                          o_frame_done
`ifdef SLIDING_WINDOW_COORD_EN
   ,
   output logic [$clog2(IMG_HEIGHT)-1:0]                 o_center_row,
   output logic [$clog2(IMG_WIDTH)-1:0]                  o_center_col
`endif
);

   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_SIZE - 1);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] win_t;

   state_t                             state_r;
   logic [ROW_W-1:0]                   row_r;
   logic [COL_W-1:0]                   col_r;
   win_t                               win_r;
   logic [NBIT-1:0]                    lb_r [KERNEL_SIZE-1][IMG_WIDTH];

   logic                               accept_s;
   logic [ROW_W-1:0]                   cur_row_s;
   logic [COL_W-1:0]                   cur_col_s;
   logic [KERNEL_SIZE-1:0][NBIT-1:0]   new_col_s;
   win_t                               shift_s;
   logic                               win_valid_s;
   logic                               last_s;

   // Pixel qualification; a start-of-frame pixel is always coordinate (0,0), even mid-frame.
   always_comb begin
      accept_s = i_pixel_valid & (i_sof | (state_r == S_ACTIVE));
      if (i_sof) begin
         cur_row_s = '0;
         cur_col_s = '0;
      end else begin
         cur_row_s = row_r;
         cur_col_s = col_r;
      end
      win_valid_s = accept_s & (cur_row_s >= ROW_FIRST) & (cur_col_s >= COL_FIRST);
      last_s      = accept_s & (cur_row_s == ROW_LAST) & (cur_col_s == COL_LAST);
   end

   // New column (oldest row first) and the window after shifting it in.
   always_comb begin
      new_col_s = '0;
      shift_s   = '0;
      for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
         new_col_s[r] = lb_r[KERNEL_SIZE-2-r][cur_col_s];
      end
      new_col_s[KERNEL_SIZE-1] = i_pixel;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
            shift_s[r][c] = win_r[r][c+1];
         end
         shift_s[r][KERNEL_SIZE-1] = new_col_s[r];
      end
   end

   // Line buffers: read-before-write at the current column, contents need no reset.
   always_ff @(posedge i_clk) begin
      if (accept_s) begin
         lb_r[0][cur_col_s] <= i_pixel;
         for (int k = 1; k < KERNEL_SIZE - 1; k++) begin
            lb_r[k][cur_col_s] <= lb_r[k-1][cur_col_s];
         end
      end
   end

   // Frame FSM, raster counters, column shift register and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r        <= S_IDLE;
         row_r          <= '0;
         col_r          <= '0;
         win_r          <= '0;
         o_window       <= '0;
         o_window_valid <= 1'b0;
         o_frame_done   <= 1'b0;
`ifdef SLIDING_WINDOW_COORD_EN
         o_center_row   <= '0;
         o_center_col   <= '0;
`endif
      end else begin
         o_window_valid <= win_valid_s;
         o_frame_done   <= last_s;
         if (accept_s) begin
            win_r <= shift_s;
            if (cur_col_s == COL_LAST) begin
               col_r <= '0;
               if (cur_row_s == ROW_LAST) begin
                  row_r   <= '0;
                  state_r <= S_IDLE;
               end else begin
                  row_r   <= cur_row_s + ROW_W'(1);
                  state_r <= S_ACTIVE;
               end
            end else begin
               col_r   <= cur_col_s + COL_W'(1);
               row_r   <= cur_row_s;
               state_r <= S_ACTIVE;
            end
         end else begin
            win_r   <= win_r;
            col_r   <= col_r;
            row_r   <= row_r;
            state_r <= state_r;
         end
         if (win_valid_s) begin
            o_window <= shift_s;
`ifdef SLIDING_WINDOW_COORD_EN
            o_center_row <= cur_row_s - ROW_W'((KERNEL_SIZE - 1) / 2);
            o_center_col <= cur_col_s - COL_W'((KERNEL_SIZE - 1) / 2);
`endif
         end else begin
            o_window <= o_window;
         end
      end
   end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Scoreboard bench for sliding_window_gen: a frame-array reference model queues expected windows,
// a negedge monitor pops and compares them. Coordinate checks are active when SLIDING_WINDOW_COORD_EN is defined.
module tb_sliding_window_gen;

   localparam int NB = 8;
   localparam int K  = 3;
   localparam int W  = 5;
   localparam int H  = 5;

   typedef logic [K-1:0][K-1:0][NB-1:0] win_t;
   typedef struct {
      win_t win;
      bit   done;
      int   crow;
      int   ccol;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] pixel;
   logic          pvalid;
   logic          sof;
   win_t          window;
   logic          wvalid;
   logic          fdone;
`ifdef SLIDING_WINDOW_COORD_EN
   logic [2:0]    crow;
   logic [2:0]    ccol;
`endif

   sliding_window_gen #(.NBIT(NB), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_pixel       (pixel),
      .i_pixel_valid (pvalid),
      .i_sof         (sof),
      .o_window      (window),
      .o_window_valid(wvalid),
      .o_frame_done  (fdone)
`ifdef SLIDING_WINDOW_COORD_EN
      ,
      .o_center_row  (crow),
      .o_center_col  (ccol)
`endif
   );

   always #5 clk = ~clk;

   exp_t          sb[$];
   int            errors = 0;
   int            checks = 0;
   bit            m_active = 1'b0;
   int            m_row = 0;
   int            m_col = 0;
   logic [NB-1:0] frame [H][W];
   int            win_cnt = 0;
   int            done_cnt = 0;
   bit            got_first = 1'b0;
   win_t          first_win;
   win_t          last_win;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Window of the test pattern pixel = row*16+col whose newest pixel is (r,c).
   function automatic win_t pat_win(input int r, input int c);
      win_t w;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            w[i][j] = 8'((r - K + 1 + i) * 16 + (c - K + 1 + j));
      return w;
   endfunction

   // Reference model: track frame position and store pixels in a 2-D frame array.
   task automatic model_pixel(input logic [NB-1:0] d, input bit s);
      exp_t e;
      if (s) begin
         m_active = 1'b1;
         m_row    = 0;
         m_col    = 0;
      end
      if (m_active) begin
         frame[m_row][m_col] = d;
         if (m_row >= K - 1 && m_col >= K - 1) begin
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  e.win[i][j] = frame[m_row-K+1+i][m_col-K+1+j];
            e.done = (m_row == H - 1) && (m_col == W - 1);
            e.crow = m_row - (K - 1) / 2;
            e.ccol = m_col - (K - 1) / 2;
            sb.push_back(e);
         end
         if (m_col == W - 1) begin
            m_col = 0;
            if (m_row == H - 1) begin
               m_row    = 0;
               m_active = 1'b0;
            end else begin
               m_row++;
            end
         end else begin
            m_col++;
         end
      end
   endtask

   task automatic drive_pixel(input logic [NB-1:0] d, input bit s);
      @(posedge clk);
      #1;
      pixel  = d;
      pvalid = 1'b1;
      sof    = s;
      model_pixel(d, s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         pvalid = 1'b0;
         sof    = 1'b0;
         pixel  = 8'($urandom);
      end
   endtask

   // Send pixels (0,0) .. up to count pixels of a frame; pattern or random data, random gaps up to gap_max.
   task automatic send_frame(input bit pattern, input int gap_max, input int count);
      int n = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (n < count) begin
               drive_pixel(pattern ? 8'(r * 16 + c) : 8'($urandom), (r == 0) && (c == 0));
               if (gap_max > 0) idle($urandom_range(gap_max, 0));
               n++;
            end
         end
      end
   endtask

   task automatic clear_stats();
      win_cnt   = 0;
      done_cnt  = 0;
      got_first = 1'b0;
   endtask

   // Monitor: every presented window must match the head of the scoreboard.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n === 1'b1 && wvalid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window: got %h, expected no window", window);
         end else begin
            e = sb.pop_front();
            check("window", window, e.win);
            check("frame_done", fdone, e.done);
`ifdef SLIDING_WINDOW_COORD_EN
            check("center_row", crow, e.crow[2:0]);
            check("center_col", ccol, e.ccol[2:0]);
`endif
            win_cnt++;
            if (fdone) done_cnt++;
            if (!got_first) first_win = window;
            got_first = 1'b1;
            last_win  = window;
         end
      end else if (rst_n === 1'b1 && fdone === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL stray_frame_done: got 1 without window valid, expected 0");
      end
   end

   initial begin
      rst_n  = 1'b0;
      pixel  = '0;
      pvalid = 1'b0;
      sof    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_window", window, '0);
      check("reset_valid", wvalid, 1'b0);
      check("reset_done", fdone, 1'b0);
      rst_n = 1'b1;

      // 1: continuous pattern frame
      clear_stats();
      send_frame(1'b1, 0, W * H);
      idle(4);
      check("t1_first_window", first_win, pat_win(2, 2));
      check("t1_last_window", last_win, pat_win(4, 4));
      check("t1_window_count", win_cnt, 9);
      check("t1_done_count", done_cnt, 1);

      // 2: same frame with random valid gaps
      clear_stats();
      send_frame(1'b1, 3, W * H);
      idle(4);
      check("t2_first_window", first_win, pat_win(2, 2));
      check("t2_last_window", last_win, pat_win(4, 4));
      check("t2_window_count", win_cnt, 9);
      check("t2_done_count", done_cnt, 1);

      // 3: idle pixels without sof are dropped
      clear_stats();
      for (int i = 0; i < 4; i++) drive_pixel(8'($urandom), 1'b0);
      send_frame(1'b1, 0, W * H);
      idle(4);
      check("t3_first_window", first_win, pat_win(2, 2));
      check("t3_window_count", win_cnt, 9);
      check("t3_done_count", done_cnt, 1);

      // 4: frame A aborted by sof at (3,1), then random frame B
      clear_stats();
      send_frame(1'b0, 1, 3 * W + 1);
      send_frame(1'b0, 1, W * H);
      idle(4);
      check("t4_window_count", win_cnt, 3 + 9);
      check("t4_done_count", done_cnt, 1);

      // 5: asynchronous reset mid-frame, then a clean pattern frame
      send_frame(1'b0, 0, 2 * W + 4);
      @(posedge clk);
      #2;
      check("t5_pre_reset_valid", wvalid, 1'b1);
      #1;
      rst_n  = 1'b0;
      pvalid = 1'b0;
      sof    = 1'b0;
      sb.delete();
      m_active = 1'b0;
      #1;
      check("t5_reset_window", window, '0);
      check("t5_reset_valid", wvalid, 1'b0);
      check("t5_reset_done", fdone, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_stats();
      send_frame(1'b1, 2, W * H);
      idle(4);
      check("t5_first_window", first_win, pat_win(2, 2));
      check("t5_last_window", last_win, pat_win(4, 4));
      check("t5_window_count", win_cnt, 9);

      // random data frames with gaps
      clear_stats();
      for (int f = 0; f < 3; f++) send_frame(1'b0, 2, W * H);
      idle(4);
      check("rand_window_count", win_cnt, 27);
      check("rand_done_count", done_cnt, 3);

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
